// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_mp_pkg;

    // Sequencer state: INIT zeroes the array one entry per cycle, RUN is normal operation.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_DATA_W = 32;

    // Narrow or widen with a size cast at the point of use.
    localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: bypass selection and the registered read-data output.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_ra,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_wa0,
    input  logic [DATA_W-1:0] i_wn0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_wa1,
    input  logic [DATA_W-1:0] i_wn1,
    output logic [DATA_W-1:0] o_rn
);

    localparam logic [DATA_W-1:0] ZERO = DATA_W'(ZERO_WORD);

    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] r_rn;

    // Write-first bypass: port 1 beats port 0, both beat the stored contents.
    always_comb begin
        w_rd_val = i_mem_data;
        if ((ZERO_REG != 0) && (i_ra == '0)) begin
            w_rd_val = ZERO;
        end else if (i_we1 && (i_wa1 == i_ra)) begin
            w_rd_val = i_wn1;
        end else if (i_we0 && (i_wa0 == i_ra)) begin
            w_rd_val = i_wn0;
        end
    end

    // Output register; cleared when the port is idle or the file is initialising.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rn <= ZERO;
        end else if (!i_run || !i_re) begin
            r_rn <= ZERO;
        end else begin
            r_rn <= w_rd_val;
        end
    end

    assign o_rn = r_rn;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, per-port
// write-first bypass and a zeroing sequencer that replaces array reset.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    output logic                     busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wn0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wn1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rn
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ZERO = DATA_W'(ZERO_WORD);

    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   w_idx_d;
    logic              w_run;
    logic              w_we0_run;
    logic              w_we1_run;
    logic              w_we0_mem;
    logic              w_we1_mem;

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign w_run = (r_state == ST_RUN);
    assign busy  = !w_run;

    // Write enables only count in RUN; the bypass sees these, the array also drops entry 0.
    assign w_we0_run = we0 && w_run;
    assign w_we1_run = we1 && w_run;
    assign w_we0_mem = w_we0_run && !((ZERO_REG != 0) && (wa0 == '0));
    assign w_we1_mem = w_we1_run && !((ZERO_REG != 0) && (wa1 == '0));

    // Sequencer state and index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
        end
    end

    // Next state: walk the index to the last entry, then run; clr always restarts.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        case (r_state)
            ST_INIT: begin
                if (r_idx == LAST_IDX) begin
                    w_state_d = ST_RUN;
                    w_idx_d   = '0;
                end else begin
                    w_idx_d = r_idx + 1'b1;
                end
            end
            ST_RUN: begin
                w_idx_d = '0;
            end
            default: begin
                w_state_d = ST_INIT;
                w_idx_d   = '0;
            end
        endcase
        if (clr) begin
            w_state_d = ST_INIT;
            w_idx_d   = '0;
        end
    end

    // Storage: zeroed by the sequencer during INIT, otherwise port 1 is written last so it wins.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_idx[ADDR_W-1:0]] <= ZERO;
        end else begin
            if (w_we0_mem) begin
                r_mem[wa0] <= wn0;
            end
            if (w_we1_mem) begin
                r_mem[wa1] <= wn1;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_mem_data;

        assign w_ra       = ra[g*ADDR_W +: ADDR_W];
        assign w_mem_data = r_mem[w_ra];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk        (clk),
            .rst        (rst),
            .i_run      (w_run),
            .i_re       (re[g]),
            .i_ra       (w_ra),
            .i_mem_data (w_mem_data),
            .i_we0      (w_we0_run),
            .i_wa0      (wa0),
            .i_wn0      (wn0),
            .i_we1      (w_we1_run),
            .i_wa1      (wa1),
            .i_wn1      (wn1),
            .o_rn       (rn[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: behavioural model compared every cycle,
// plus directed vectors with literal expected values.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          busy;
    logic          we0 = 1'b0;
    logic [AW-1:0] wa0 = '0;
    logic [DW-1:0] wn0 = '0;
    logic          we1 = 1'b0;
    logic [AW-1:0] wa1 = '0;
    logic [DW-1:0] wn1 = '0;
    logic [NR-1:0] re  = '0;
    logic [AW-1:0] ra0 = '0;
    logic [AW-1:0] ra1 = '0;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rn;
    logic [DW-1:0] rn0;
    logic [DW-1:0] rn1;

    assign ra  = {ra1, ra0};
    assign rn0 = rn[DW-1:0];
    assign rn1 = rn[2*DW-1:DW];

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .busy (busy),
        .we0  (we0),
        .wa0  (wa0),
        .wn0  (wn0),
        .we1  (we1),
        .wa1  (wa1),
        .wn1  (wn1),
        .re   (re),
        .ra   (ra),
        .rn   (rn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an array of words and a count of zeroing cycles still to go.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left = DEPTH;
    logic [DW-1:0] m_rn [NR];

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0)              return '0;
        if (we1 && wa1 == a)     return wn1;
        if (we0 && wa0 == a)     return wn0;
        return m_mem[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = DEPTH;
            for (int i = 0; i < NR; i++) m_rn[i] = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            m_rn[0] = (m_left == 0 && re[0]) ? m_read(ra0) : '0;
            m_rn[1] = (m_left == 0 && re[1]) ? m_read(ra1) : '0;
            if (m_left == 0) begin
                if (we0 && wa0 != 0) m_mem[wa0] = wn0;
                if (we1 && wa1 != 0) m_mem[wa1] = wn1;
            end else begin
                m_left--;
            end
            if (clr) begin
                m_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
        end
    end

    // Compare process: every cycle, just after the edge.
    always @(posedge clk) begin
        #1;
        check("cyc_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
        check("cyc_rn0", rn0, m_rn[0]);
        check("cyc_rn1", rn1, m_rn[1]);
    end

    task automatic idle();
        we0 = 0; we1 = 0; re = '0; clr = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Counts cycles until busy drops, bounded.
    task automatic wait_init(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cyc();
            cnt++;
            idle();
        end
    endtask

    int cnt;

    initial begin
        idle();
        repeat (3) cyc();
        check("reset_busy", {31'b0, busy}, 32'd1);
        check("reset_rn0", rn0, 32'h0);
        rst = 0;
        wait_init(cnt);
        check("init_len", cnt, 32'd32);

        // Every entry reads zero after init.
        for (int a = 0; a < DEPTH; a += 2) begin
            re = 2'b11; ra0 = AW'(a); ra1 = AW'(a + 1);
            cyc();
            check("init_zero0", rn0, 32'h0);
            check("init_zero1", rn1, 32'h0);
        end
        idle();

        // Plain write then read.
        we0 = 1; wa0 = 5; wn0 = 32'hDEADBEEF;
        cyc(); idle();
        re = 2'b01; ra0 = 5;
        cyc(); idle();
        check("wr_rd5", rn0, 32'hDEADBEEF);
        cyc();
        check("re_off_zero", rn0, 32'h0);

        // Both ports to one address: port 1 wins, bypass and storage.
        we0 = 1; wa0 = 7; wn0 = 32'h11;
        we1 = 1; wa1 = 7; wn1 = 32'h22;
        re = 2'b10; ra1 = 7;
        cyc(); idle();
        check("byp_prio", rn1, 32'h22);
        re = 2'b01; ra0 = 7;
        cyc(); idle();
        check("prio_store", rn0, 32'h22);

        // Port 0 bypass seen on both read ports.
        we0 = 1; wa0 = 9; wn0 = 32'hA5A5A5A5;
        re = 2'b11; ra0 = 9; ra1 = 9;
        cyc(); idle();
        check("byp0_p0", rn0, 32'hA5A5A5A5);
        check("byp0_p1", rn1, 32'hA5A5A5A5);

        // Entry 0 hardwired to zero.
        we1 = 1; wa1 = 0; wn1 = 32'hFFFFFFFF;
        re = 2'b01; ra0 = 0;
        cyc(); idle();
        check("zero_byp", rn0, 32'h0);
        re = 2'b11; ra0 = 0; ra1 = 0;
        cyc(); idle();
        check("zero_rd0", rn0, 32'h0);
        check("zero_rd1", rn1, 32'h0);

        // clr restarts init; writes during init are dropped.
        we0 = 1; wa0 = 3; wn0 = 32'h1234;
        cyc(); idle();
        re = 2'b01; ra0 = 3;
        cyc(); idle();
        check("pre_clr3", rn0, 32'h1234);
        clr = 1;
        cyc(); idle();
        check("clr_busy", {31'b0, busy}, 32'd1);
        we0 = 1; wa0 = 3; wn0 = 32'h55;
        re = 2'b11; ra0 = 3; ra1 = 5;
        cyc(); idle();
        check("init_rd0", rn0, 32'h0);
        check("init_rd1", rn1, 32'h0);
        wait_init(cnt);
        check("clr_len", cnt + 1, 32'd32);
        re = 2'b11; ra0 = 3; ra1 = 5;
        cyc(); idle();
        check("post_clr3", rn0, 32'h0);
        check("post_clr5", rn1, 32'h0);

        // Async reset mid-run, checked before the next edge.
        we0 = 1; wa0 = 4; wn0 = 32'hCAFE;
        cyc(); idle();
        re = 2'b01; ra0 = 4;
        cyc();
        check("pre_rst4", rn0, 32'hCAFE);
        #2 rst = 1;
        #1;
        check("async_busy", {31'b0, busy}, 32'd1);
        check("async_rn0", rn0, 32'h0);
        idle();
        cyc();
        rst = 0;
        wait_init(cnt);
        check("rst_len", cnt, 32'd32);
        re = 2'b01; ra0 = 4;
        cyc(); idle();
        check("post_rst4", rn0, 32'h0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read file in the decode stage.
- Configurable width, depth and read-port count; two write ports with fixed priority.
- Per-port write-first bypass; registered read data.
- Built-in init/clear sequencer that zeroes storage after reset or on request, so reset does not fan out to the array.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes ignored, reads return 0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
clr  in  1  pulse: restart the init sequence (zero all entries)
busy  out  1  high while init sequence is running
we0  in  1  write enable, port 0
wa0  in  ADDR_W  write address, port 0
wn0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (priority port)
wa1  in  ADDR_W  write address, port 1
wn1  in  DATA_W  write data, port 1
re  in  NUM_RD  read enable per port
ra  in  NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
rn  out  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]

Behaviour:
- Reset: asynchronous on rst=1.
  - FSM -> INIT, init index = 0, busy = 1, all rn = 0.
  - Storage array is not reset directly.
- FSM states:
  - INIT: each cycle write 0 to entry[index] and increment index. After the cycle that writes DEPTH-1 -> RUN, busy = 0. INIT takes exactly DEPTH cycles after rst deasserts.
  - RUN: normal operation.
  - clr=1 in any state -> INIT with index 0 on the next edge. clr during INIT restarts from 0.
- During INIT:
  - we0/we1 ignored; entries are written only by the sequencer.
  - All rn registered to 0 regardless of re.
- Write (RUN): on the rising edge, entry[wa0] <= wn0 if we0; entry[wa1] <= wn1 if we1.
  - Same address on both ports with both enabled: port 1 wins.
  - ZERO_REG=1 and address 0: write dropped.
- Read (RUN): latency 1 cycle. rn[i] registers on the edge where re[i]=1.
  - re[i]=0 -> rn[i] <= 0 (not hold).
  - Bypass priority for rn[i] value:
    1. ZERO_REG=1 and ra[i]==0 -> 0.
    2. we1 && wa1==ra[i] -> wn1.
    3. we0 && wa0==ra[i] -> wn0.
    4. Otherwise entry[ra[i]] (pre-edge contents).
  - All read ports are independent; the same address on several ports is legal.
- Arithmetic: index is an ADDR_W+1-bit counter; the terminal condition is index == DEPTH-1 during INIT. No wrap into RUN mid-sequence.
- rst asserted mid-INIT or mid-RUN: immediate async return to INIT/index 0. In-flight writes that cycle are discarded.

Decomposition:
- Shared package: FSM state encoding (ST_INIT, ST_RUN) and a zero-word constant sized by DATA_W.
- One natural sub-module: regfile_rd_port (one instance per read port via generate). It holds the bypass mux and the rn output register.
- Array, write logic and FSM stay in regfile_mp.

Test Plan:
- Reset release, DEPTH=32 -> busy=1 for exactly 32 cycles then 0. Read of every address after busy falls returns 0x00000000.
- RUN: we0, wa0=5, wn0=0xDEADBEEF; next cycle re[0], ra0=5 -> rn0=0xDEADBEEF one cycle later.
- Same cycle: we0 wa0=7 wn0=0x11, we1 wa1=7 wn1=0x22, re[1] ra1=7.
  - Bypass gives rn1=0x22.
  - Later read of 7 returns 0x22.
- ZERO_REG=1: we1 wa1=0 wn1=0xFFFFFFFF with re[0] ra0=0 -> rn0=0 that cycle and on every later read of 0.
- Write 0x1234 to entry 3, pulse clr, then write 0x55 to 3 during INIT:
  - busy reasserts for 32 cycles.
  - Reads during INIT give 0.
  - After INIT, entry 3 reads 0 (write ignored).
- Assert rst asynchronously mid-RUN, with no clock edge before it -> rn all 0 and busy=1 immediately, before the next clock edge.
